// File: rtl/coin_pkg.sv
// coin_pkg: types shared by the coin acceptor and the downstream vending FSM.
//   coin_t      - 2-bit coin code driven to the vending FSM
//   acc_state_t - acceptor FSM state
//   sense_to_coin / bits_set - helpers on the synchronized sensor vector
//                              {pentagon, triangle, circle}
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_3    = 2'b10,
    COIN_5    = 2'b11
  } coin_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EMIT,
    ST_REJECT,
    ST_WAIT_RELEASE
  } acc_state_t;

  function automatic coin_t sense_to_coin(input logic [2:0] s);
    case (s)
      3'b001:  return COIN_1;
      3'b010:  return COIN_3;
      3'b100:  return COIN_5;
      default: return COIN_NONE;
    endcase
  endfunction

  function automatic logic [1:0] bits_set(input logic [2:0] s);
    return {1'b0, s[0]} + {1'b0, s[1]} + {1'b0, s[2]};
  endfunction

endpackage

// File: rtl/coin_sync.sv
// coin_sync: two-flop synchronizer for one raw, asynchronous coin sensor.
//   clock - sampling clock
//   reset - async active-high, clears both flops
//   d     - raw sensor input
//   q     - synchronized output (two clock edges of latency)
module coin_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces three coin sensors and emits a one-cycle coin code,
// or a one-cycle reject pulse when more than one sensor fires at once.
//   clock          - single clock, rising edge
//   reset          - async active-high
//   sense_circle   - raw sensor, value-1 coin
//   sense_triangle - raw sensor, value-3 coin
//   sense_pentagon - raw sensor, value-5 coin
//   coin           - coin code (coin_t), nonzero only in EMIT
//   busy           - high whenever the FSM is not IDLE
//   reject         - one-cycle pulse on a sensor conflict
//   reject_count   - saturating count of rejects (only with
//                    COIN_ACCEPTOR_REJECT_CNT_EN defined)
// Parameter DEBOUNCE_CYCLES (1..255): matching synchronized cycles needed
// in SETTLE before the coin is accepted.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense_circle,
  input  logic       sense_triangle,
  input  logic       sense_pentagon,
  output logic [1:0] coin,
  output logic       busy,
  output logic       reject
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
  ,
  output logic [7:0] reject_count
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [2:0] raw, s;
  assign raw = {sense_pentagon, sense_triangle, sense_circle};

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_sync
      coin_sync u_sync (.clock(clock), .reset(reset), .d(raw[g]), .q(s[g]));
    end
  endgenerate

  acc_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    latched;
  coin_t         coin_q;

  assign coin = coin_q;

  // Outputs are registered alongside the state transition so they line up
  // with the state they belong to (coin in EMIT, reject in REJECT).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      latched <= 3'b000;
      coin_q  <= COIN_NONE;
      busy    <= 1'b0;
      reject  <= 1'b0;
    end else begin
      coin_q <= COIN_NONE;
      reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bits_set(s) == 2'd1) begin
            latched <= s;
            cnt     <= '0;
            state   <= ST_SETTLE;
            busy    <= 1'b1;
          end else if (s != 3'b000) begin
            state  <= ST_REJECT;
            reject <= 1'b1;
            busy   <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SETTLE: begin
          // Any change, including a drop to 000, abandons the insertion silently.
          if (s != latched) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= ST_EMIT;
            coin_q <= sense_to_coin(latched);
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_EMIT, ST_REJECT: state <= ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: begin
          if (s == 3'b000) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
  // Counts on the same edge that raises the reject pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      reject_count <= 8'd0;
    else if (state == ST_IDLE && bits_set(s) > 2'd1 && reject_count != 8'hFF)
      reject_count <= reject_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;
  localparam int DEB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sense_circle = 1'b0, sense_triangle = 1'b0, sense_pentagon = 1'b0;
  logic [1:0] coin;
  logic busy, reject;
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
  logic [7:0] reject_count;
`endif

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset),
    .sense_circle(sense_circle), .sense_triangle(sense_triangle),
    .sense_pentagon(sense_pentagon),
    .coin(coin), .busy(busy), .reject(reject)
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
    , .reject_count(reject_count)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  // Reference model. The block sees each raw vector two edges after it is
  // sampled; an insertion is a run of identical single-sensor vectors, and
  // the coin appears when that run reaches DEB+1 observations. After a coin
  // or reject the block ignores one edge, then waits for an all-clear.
  localparam int FREE = 0, RUN = 1, DONE = 2, HOLD = 3;
  logic [2:0] hist[$];
  int         phase = FREE;
  logic [2:0] lat;
  int         run;
  int         rc = 0;
  logic [1:0] e_coin = 2'b00;
  logic       e_rej = 1'b0, e_busy = 1'b0;

  function automatic logic [1:0] code_of(input logic [2:0] v);
    if (v == 3'b001) return 2'b01;
    if (v == 3'b010) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_clear();
    hist.delete();
    phase = FREE; run = 0; rc = 0;
    e_coin = 2'b00; e_rej = 1'b0; e_busy = 1'b0;
  endtask

  // Drive raw vector, take one edge, advance the model, settle 1 time unit.
  task automatic step(input logic [2:0] v);
    logic [2:0] s;
    {sense_pentagon, sense_triangle, sense_circle} = v;
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      s = (hist.size() >= 2) ? hist[hist.size()-2] : 3'b000;
      e_coin = 2'b00; e_rej = 1'b0;
      case (phase)
        FREE: if ($countones(s) == 1) begin phase = RUN; lat = s; run = 1; end
              else if (s != 3'b000) begin phase = DONE; e_rej = 1'b1; if (rc < 255) rc++; end
        RUN:  if (s != lat) phase = FREE;
              else begin run++; if (run == DEB + 1) begin phase = DONE; e_coin = code_of(lat); end end
        DONE: phase = HOLD;
        default: if (s == 3'b000) phase = FREE;
      endcase
      e_busy = (phase != FREE);
      hist.push_back(v);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {sense_pentagon, sense_triangle, sense_circle} = 3'b111;
    repeat (2) @(posedge clock);
    #1;
    model_clear();
    n_cmp++;
    if ({coin, busy, reject} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_state: coin/busy/reject=%b/%b/%b want 00/0/0", coin, busy, reject);
    end
    {sense_pentagon, sense_triangle, sense_circle} = 3'b000;
    reset = 1'b0;
    repeat (3) step(3'b000);
  endtask

  // Triangle held 10 cycles: one coin 10, DEB+2 edges after first sample.
  task automatic test_single();
    int ncoin = 0, at = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 10 ? 3'b010 : 3'b000);
      n_cmp++;
      if ({coin, busy, reject} !== {e_coin, e_busy, e_rej}) begin
        n_bad++; $display("FAIL single cyc%0d: c/b/r=%b/%b/%b want %b/%b/%b", i, coin, busy, reject, e_coin, e_busy, e_rej);
      end
      if (coin == 2'b10) begin ncoin++; at = i; end
    end
    n_cmp++;
    if (ncoin != 1 || at != DEB + 2) begin
      n_bad++; $display("FAIL single_latency: coins=%0d at edge %0d want 1 at %0d", ncoin, at, DEB + 2);
    end
  endtask

  // Short burst aborted by a one-cycle glitch, then a real insertion.
  task automatic test_glitch();
    int ncoin = 0, nrej = 0;
    logic [2:0] pat[$];
    repeat (3) pat.push_back(3'b001);
    pat.push_back(3'b000);
    repeat (10) pat.push_back(3'b001);
    repeat (6) pat.push_back(3'b000);
    foreach (pat[i]) begin
      step(pat[i]);
      n_cmp++;
      if ({coin, busy, reject} !== {e_coin, e_busy, e_rej}) begin
        n_bad++; $display("FAIL glitch cyc%0d: c/b/r=%b/%b/%b want %b/%b/%b", i, coin, busy, reject, e_coin, e_busy, e_rej);
      end
      if (coin != 2'b00) begin
        ncoin++;
        if (i < 6) begin n_bad++; $display("FAIL glitch_first_burst: coin %b at cyc%0d want 00", coin, i); end
      end
      nrej += reject;
    end
    n_cmp++;
    if (ncoin != 1 || nrej != 0) begin
      n_bad++; $display("FAIL glitch_counts: coins=%0d rejects=%0d want 1/0", ncoin, nrej);
    end
  endtask

  // Circle and pentagon together: one reject, no coin, busy until both low.
  task automatic test_conflict();
    int nrej = 0, ncoin = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 8 ? 3'b101 : (i < 10 ? 3'b100 : 3'b000));
      n_cmp++;
      if ({coin, busy, reject} !== {e_coin, e_busy, e_rej}) begin
        n_bad++; $display("FAIL conflict cyc%0d: c/b/r=%b/%b/%b want %b/%b/%b", i, coin, busy, reject, e_coin, e_busy, e_rej);
      end
      nrej += reject;
      if (coin != 2'b00) ncoin++;
      if (i >= 3 && i <= 11 && !busy) begin
        n_bad++; $display("FAIL conflict_busy: busy=0 at cyc%0d want 1", i);
      end
    end
    n_cmp++;
    if (nrej != 1 || ncoin != 0) begin
      n_bad++; $display("FAIL conflict_counts: rejects=%0d coins=%0d want 1/0", nrej, ncoin);
    end
  endtask

  // Pentagon held 50 cycles, released, inserted again: two coins total.
  task automatic test_back_to_back();
    int ncoin = 0;
    for (int i = 0; i < 90; i++) begin
      step((i < 50 || (i >= 56 && i < 70)) ? 3'b100 : 3'b000);
      n_cmp++;
      if ({coin, busy, reject} !== {e_coin, e_busy, e_rej}) begin
        n_bad++; $display("FAIL hold cyc%0d: c/b/r=%b/%b/%b want %b/%b/%b", i, coin, busy, reject, e_coin, e_busy, e_rej);
      end
      if (coin == 2'b11) ncoin++;
      if (i == 55 && ncoin != 1) begin
        n_bad++; $display("FAIL hold_first: coins=%0d after 50-cycle hold want 1", ncoin);
      end
    end
    n_cmp++;
    if (ncoin != 2) begin
      n_bad++; $display("FAIL hold_second: coins=%0d want 2", ncoin);
    end
  endtask

  // Reset mid-SETTLE with triangle held: pending coin dropped, new insertion.
  task automatic test_reset_settle();
    int ncoin = 0, at = -1, guard = 0;
    while (!(phase == RUN && run == 3) && guard < 20) begin step(3'b010); guard++; ncoin += (coin != 2'b00); end
    n_cmp++;
    if (guard >= 20 || ncoin != 0) begin
      n_bad++; $display("FAIL rst_settle_pre: guard=%0d coins=%0d want <20/0", guard, ncoin);
    end
    reset = 1'b1;
    #1;
    model_clear();
    n_cmp++;
    if ({coin, busy, reject} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_settle_async: c/b/r=%b/%b/%b want 00/0/0", coin, busy, reject);
    end
    step(3'b010);
    step(3'b010);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(i < 10 ? 3'b010 : 3'b000);
      n_cmp++;
      if ({coin, busy, reject} !== {e_coin, e_busy, e_rej}) begin
        n_bad++; $display("FAIL rst_settle cyc%0d: c/b/r=%b/%b/%b want %b/%b/%b", i, coin, busy, reject, e_coin, e_busy, e_rej);
      end
      if (coin == 2'b10) begin ncoin++; at = i; end
    end
    n_cmp++;
    if (ncoin != 1 || at != DEB + 2) begin
      n_bad++; $display("FAIL rst_settle_latency: coins=%0d at %0d want 1 at %0d", ncoin, at, DEB + 2);
    end
  endtask

  // Random segments: single sensors of random length, gaps, conflicts,
  // direct sensor-to-sensor switches.
  task automatic test_random();
    logic [2:0] v;
    int len;
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin v = 3'b001 << $urandom_range(0, 2); len = $urandom_range(1, 12); end
        6, 7:             begin v = 3'b000; len = $urandom_range(1, 4); end
        8:                begin v = 3'(($urandom_range(0, 3) == 0) ? 7 : (3'b011 << $urandom_range(0, 1))); len = $urandom_range(1, 6); end
        default:          begin v = 3'b001 << $urandom_range(0, 2); len = $urandom_range(1, 3); end
      endcase
      for (int j = 0; j < len; j++) begin
        step(v);
        n_cmp++;
        if ({coin, busy, reject} !== {e_coin, e_busy, e_rej}) begin
          n_bad++; $display("FAIL random seg%0d: c/b/r=%b/%b/%b want %b/%b/%b", seg, coin, busy, reject, e_coin, e_busy, e_rej);
        end
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
        n_cmp++;
        if (reject_count !== 8'(rc)) begin
          n_bad++; $display("FAIL random_rcnt seg%0d: %0d want %0d", seg, reject_count, rc);
        end
`endif
      end
    end
    repeat (8) step(3'b000);
  endtask

`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
  task automatic test_reject_count();
    reset = 1'b1; #1; model_clear(); reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      repeat (2) step(3'b101);
      repeat (4) step(3'b000);
    end
    n_cmp++;
    if (reject_count !== 8'd255 || rc != 255) begin
      n_bad++; $display("FAIL rcnt_saturate: %0d (model %0d) want 255", reject_count, rc);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (reject_count !== 8'd0) begin
      n_bad++; $display("FAIL rcnt_reset: %0d want 0", reject_count);
    end
    model_clear();
    step(3'b000);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_conflict();
    test_back_to_back();
    test_reset_settle();
    test_random();
`ifdef COIN_ACCEPTOR_REJECT_CNT_EN
    test_reject_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
